// File: rtl/auction_bid_collector_if.sv
// Bid-collector port bundle: bid input handshake, round output handshake and status.
// The master side offers bids and consumes rounds; the slave side is the collector.
interface auction_bid_collector_if #(
  parameter int N = 2,
  parameter int W = 16
);
  logic                bid_valid;
  logic                bid_ready;
  logic [N-1:0]        bid_id;
  logic [W-1:0]        bid_value;
  logic                close;
  logic                out_valid;
  logic                out_ready;
  logic [(2**N)*W-1:0] p_input;
  logic [2**N-1:0]     received;
  logic [N:0]          count;
  logic                dup_err;
  logic                dbg_state;

  modport master (
    output bid_valid, bid_id, bid_value, close, out_ready,
    input  bid_ready, out_valid, p_input, received, count, dup_err, dbg_state
  );

  modport slave (
    input  bid_valid, bid_id, bid_value, close, out_ready,
    output bid_ready, out_valid, p_input, received, count, dup_err, dbg_state
  );
endinterface

// File: rtl/auction_bid_collector.sv
// Collects one bid per bidder slot, then holds the packed round until the
// downstream stage takes it.
module auction_bid_collector #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  auction_bid_collector_if.slave    bus
);
  localparam int NB = 2**N;
  localparam logic [N:0] LAST = (N+1)'(NB - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. bid_ready is high only in COLLECT, out_valid only in HOLD.
  state_t            state_q, state_d;
  logic [NB*W-1:0]   slots_q, slots_d;
  logic [NB-1:0]     received_q, received_d;
  logic [N:0]        count_q, count_d;
  logic              dup_err_q, dup_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      slots_q    <= '0;
      received_q <= '0;
      count_q    <= '0;
      dup_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slots_q    <= slots_d;
      received_q <= received_d;
      count_q    <= count_d;
      dup_err_q  <= dup_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slots_d    = slots_q;
    received_d = received_q;
    count_d    = count_q;
    dup_err_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        // A bid in the same cycle as close is processed before the round closes.
        if (bus.bid_valid) begin
          if (received_q[bus.bid_id]) begin
            dup_err_d = 1'b1;
          end else begin
            slots_d[bus.bid_id*W +: W] = bus.bid_value;
            received_d[bus.bid_id]     = 1'b1;
            count_d                    = count_q + (N+1)'(1);
            if (count_q == LAST) state_d = HOLD;
          end
        end
        if (bus.close) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d    = COLLECT;
          slots_d    = '0;
          received_d = '0;
          count_d    = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.bid_ready = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.p_input   = slots_q;
  assign bus.received  = received_q;
  assign bus.count     = count_q;
  assign bus.dup_err   = dup_err_q;
  assign bus.dbg_state = state_q;
endmodule
